// File: rtl/crc_checker.sv
// Serial CRC checker: divides a captured {data, remainder} codeword by a runtime
// divisor, one bit per cycle. Optional error counter under CRC_CHK_ERRCNT_EN.
module crc_checker #(
  parameter int DATA_WIDTH = 10,
  parameter int DIV_WIDTH  = 6
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              valid_in,
  input  logic [DATA_WIDTH+DIV_WIDTH-2:0]   codeword,
  input  logic [DIV_WIDTH-1:0]              divisor,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic [DIV_WIDTH-2:0]              syndrome,
  output logic                              crc_err,
  output logic                              valid_out,
  output logic                              busy,
  output logic [1:0]                        state_dbg_o
`ifdef CRC_CHK_ERRCNT_EN
  ,
  output logic [7:0]                        err_count
`endif
);

  localparam int CW    = DATA_WIDTH + DIV_WIDTH - 1;
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  // Handshake: valid_in is a request sampled only while IDLE (busy=0); there is
  // no back-pressure, and valid_out is a single-cycle strobe with results held after.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]    r_q, r_d;
  logic [DIV_WIDTH-1:0]    div_q, div_d;
  logic [DATA_WIDTH-2:0]   low_q, low_d;
  logic [DATA_WIDTH-1:0]   dcap_q, dcap_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DIV_WIDTH-2:0]    syn_q, syn_d;
  logic                    err_q, err_d;
  logic                    vout_q, vout_d;
  logic [DIV_WIDTH-1:0]    t_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      div_q   <= '0;
      low_q   <= '0;
      dcap_q  <= '0;
      data_q  <= '0;
      syn_q   <= '0;
      err_q   <= 1'b0;
      vout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      div_q   <= div_d;
      low_q   <= low_d;
      dcap_q  <= dcap_d;
      data_q  <= data_d;
      syn_q   <= syn_d;
      err_q   <= err_d;
      vout_q  <= vout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    div_d   = div_q;
    low_d   = low_q;
    dcap_d  = dcap_q;
    data_d  = data_q;
    syn_d   = syn_q;
    err_d   = err_q;
    vout_d  = 1'b0;
    t_w     = r_q[DIV_WIDTH-1] ? (r_q ^ div_q) : r_q;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          r_d     = codeword[CW-1:CW-DIV_WIDTH];
          low_d   = codeword[CW-DIV_WIDTH-1:0];
          dcap_d  = codeword[CW-1:DIV_WIDTH-1];
          div_d   = divisor;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == LAST_CNT) begin
          syn_d   = t_w[DIV_WIDTH-2:0];
          data_d  = dcap_q;
          // A divisor without its top bit set is not a valid generator.
          err_d   = (|t_w[DIV_WIDTH-2:0]) | ~div_q[DIV_WIDTH-1];
          vout_d  = 1'b1;
          state_d = DONE;
        end else begin
          r_d   = {t_w[DIV_WIDTH-2:0], low_q[DATA_WIDTH-2]};
          low_d = low_q << 1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data_out    = data_q;
  assign syndrome    = syn_q;
  assign crc_err     = err_q;
  assign valid_out   = vout_q;
  assign busy        = (state_q != IDLE);
  assign state_dbg_o = state_q;

`ifdef CRC_CHK_ERRCNT_EN
  logic [7:0] ecnt_q, ecnt_d;

  always_comb begin
    ecnt_d = ecnt_q;
    if (vout_d && err_d && (ecnt_q != 8'hFF)) begin
      ecnt_d = ecnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt_q <= 8'd0;
    end else begin
      ecnt_q <= ecnt_d;
    end
  end

  assign err_count = ecnt_q;
`endif

endmodule
